// File: rtl/axis_spi_pkg.sv
// Shared types and SPI mode decoding for the AXI-Stream SPI master.
package axis_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  // SPI_MODE is encoded as {CPOL,CPHA}.
  function automatic logic mode_cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic mode_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake plus data.
interface axis_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles spi_clk every CLK_DIV cycles while enabled and flags
// the leading/trailing edge in the cycle the toggle is registered.
module spi_clk_gen
  import axis_spi_pkg::*;
#(
  parameter int   CLK_DIV = 4,
  parameter logic CPOL    = 1'b0
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic enable,
  output logic leading_edge,
  output logic trailing_edge,
  output logic spi_clk
);

  localparam int             DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             spi_clk_reg;
  logic             edge_now;

  assign edge_now      = enable && (div_cnt_reg == DIV_LAST);
  // An edge leaving the idle level is the leading one.
  assign leading_edge  = edge_now && (spi_clk_reg == CPOL);
  assign trailing_edge = edge_now && (spi_clk_reg != CPOL);
  assign spi_clk       = spi_clk_reg;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      div_cnt_reg <= '0;
      spi_clk_reg <= CPOL;
    end else if (!enable) begin
      div_cnt_reg <= '0;
      spi_clk_reg <= CPOL;
    end else if (edge_now) begin
      div_cnt_reg <= '0;
      spi_clk_reg <= ~spi_clk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/axis_spi_master.sv
// SPI master: one AXIS word in is shifted out MSB-first on MOSI while the MISO
// word is collected and presented on the AXIS output after CS deasserts.
module axis_spi_master
  import axis_spi_pkg::*;
#(
  parameter int SPI_MODE   = 0,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic   clk_i,
  input  logic   arstn_i,
  axis_if.slave  s_axis,
  axis_if.master m_axis,
  output logic   spi_clk_o,
  output logic   spi_cs_o,
  output logic   spi_mosi_o,
  input  logic   spi_miso_i
);

  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);

  localparam int               BIT_W      = $clog2(2 * DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * DATA_WIDTH - 1);
  localparam int               DIV_W      = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);

  spi_state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [DIV_W-1:0]      phase_cnt_reg;
  logic                  cs_reg;
  logic                  m_valid_reg;

  logic s_ready;
  logic s_fire;
  logic phase_done;
  logic leading_edge;
  logic trailing_edge;
  logic last_edge;
  logic sample_en;
  logic shift_en;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .enable        (state_reg == SHIFT),
    .leading_edge  (leading_edge),
    .trailing_edge (trailing_edge),
    .spi_clk       (spi_clk_o)
  );

  // Accepting only with an empty output slot means RX can never overflow.
  assign s_ready    = arstn_i && (state_reg == IDLE) && !m_valid_reg;
  assign s_fire     = s_ready && s_axis.tvalid;
  assign phase_done = (phase_cnt_reg == PHASE_LAST);
  assign last_edge  = (leading_edge || trailing_edge) && (bit_cnt_reg == BIT_LAST);

  // CPHA=1 presents the MSB before the first leading edge, so that edge does not shift.
  assign sample_en = CPHA ? trailing_edge : leading_edge;
  assign shift_en  = CPHA ? (leading_edge && (bit_cnt_reg != '0))
                          : (trailing_edge && (bit_cnt_reg != BIT_LAST));

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid_reg;
  assign m_axis.tdata  = m_data_reg;
  assign spi_cs_o      = cs_reg;
  assign spi_mosi_o    = !cs_reg && tx_reg[DATA_WIDTH-1];

  always_ff @(posedge clk_i) begin
    if (!arstn_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (s_fire)     state_next = SETUP;
      SETUP:   if (phase_done) state_next = SHIFT;
      SHIFT:   if (last_edge)  state_next = HOLD;
      HOLD:    if (phase_done) state_next = GAP;
      GAP:     if (phase_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      tx_reg        <= '0;
      rx_reg        <= '0;
      m_data_reg    <= '0;
      bit_cnt_reg   <= '0;
      phase_cnt_reg <= '0;
      cs_reg        <= 1'b1;
      m_valid_reg   <= 1'b0;
    end else begin
      if ((state_reg inside {SETUP, HOLD, GAP}) && !phase_done)
        phase_cnt_reg <= phase_cnt_reg + 1'b1;
      else
        phase_cnt_reg <= '0;

      if (m_valid_reg && m_axis.tready)
        m_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (s_fire) begin
            tx_reg      <= s_axis.tdata;
            rx_reg      <= '0;
            bit_cnt_reg <= '0;
            cs_reg      <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_edge)
            bit_cnt_reg <= '0;
          else if (leading_edge || trailing_edge)
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (sample_en)
            rx_reg <= {rx_reg[DATA_WIDTH-2:0], spi_miso_i};
          if (shift_en)
            tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
        end
        HOLD: begin
          if (phase_done) begin
            cs_reg      <= 1'b1;
            m_valid_reg <= 1'b1;
            m_data_reg  <= rx_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axis_spi_master.md
AXIS_SPI_MASTER -- requirements
Module: axis_spi_master

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, meaning the SPI mode 0..3 as {CPOL,CPHA}.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the bits per SPI frame and the AXIS tdata width.
REQ-003 SHALL have parameter CLK_DIV, default 4, meaning the SCLK half-period in clk_i cycles; legal values are 2 or more.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-005 SHALL have port arstn_i, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port s_axis, axis_if.slave, DATA_WIDTH: the word to transmit on MOSI.
REQ-007 SHALL have port m_axis, axis_if.master, DATA_WIDTH: the word received on MISO.
REQ-008 SHALL have port spi_clk_o, output, 1 bit: SCLK.
REQ-009 SHALL have port spi_cs_o, output, 1 bit: active-low chip select.
REQ-010 SHALL have port spi_mosi_o, output, 1 bit: master-out data.
REQ-011 SHALL have port spi_miso_i, input, 1 bit: master-in data.

Function
REQ-012 SHALL implement an FSM with states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-013 SHALL drive s_axis.tready high only in IDLE while m_axis.tvalid is low; there is no RX overflow by construction.
REQ-014 SHALL, on an s_axis handshake in IDLE:
- latch tdata into the TX shift register;
- go to SETUP;
- drive spi_cs_o low on the next cycle.
REQ-015 SHALL drive spi_mosi_o with the TX MSB throughout SETUP, and SETUP SHALL last CLK_DIV cycles.
REQ-016 SHALL, in SHIFT, toggle spi_clk_o every CLK_DIV cycles, for exactly 2*DATA_WIDTH edges.
REQ-017 SHALL hold spi_clk_o at CPOL in every state except SHIFT.
REQ-018 SHALL, for CPHA=0:
- sample spi_miso_i on leading (odd) edges;
- shift MOSI on trailing edges, except the final trailing edge.
REQ-019 SHALL, for CPHA=1:
- shift MOSI on leading edges (the first leading edge presents the MSB);
- sample spi_miso_i on trailing edges.
REQ-020 SHALL sample spi_miso_i into the RX shift register MSB-first, in the clk_i cycle in which the sampling edge is driven.
REQ-021 SHALL enter HOLD after the last edge, and HOLD SHALL keep spi_cs_o low for CLK_DIV cycles.
REQ-022 SHALL, when HOLD ends:
- drive spi_cs_o high;
- assert m_axis.tvalid with the RX word, both in the same cycle;
- enter GAP.
REQ-023 SHALL hold spi_cs_o high in GAP for CLK_DIV cycles, then return to IDLE.
REQ-024 SHALL give a CS-low time of exactly (2*DATA_WIDTH+2)*CLK_DIV cycles per frame.
REQ-025 SHALL keep m_axis.tvalid and tdata stable until m_axis.tready is high, clearing tvalid on the cycle after the handshake.
REQ-026 SHALL hold spi_mosi_o at 0 while spi_cs_o is high.
REQ-027 SHALL size the bit counter as $clog2(2*DATA_WIDTH) bits and the divider counter as $clog2(CLK_DIV) bits; neither counter wraps inside a frame.
REQ-028 SHALL ignore s_axis.tvalid outside IDLE; a word offered mid-frame waits.

Reset
REQ-029 SHALL, while arstn_i is low at a rising edge of clk_i, force all of the following, mid-frame included:
- state to IDLE;
- spi_cs_o to 1;
- spi_clk_o to CPOL;
- spi_mosi_o to 0;
- m_axis.tvalid to 0 and m_axis.tdata to 0;
- s_axis.tready to 0;
- all counters to 0.
REQ-030 SHALL discard a partially shifted frame on reset and emit no m_axis word for it.

Structure
REQ-031 SHALL place the state enum and the CPOL/CPHA decode functions in package axis_spi_pkg.
REQ-032 SHALL implement the divider and edge generation as sub-module spi_clk_gen.
- Outputs: leading_edge, trailing_edge, spi_clk.
- Inputs: enable, CLK_DIV.

Verification
REQ-033 SHALL cover: mode 0, CLK_DIV=2, DATA_WIDTH=8, MISO looped to MOSI, send 0xA5.
- m_axis receives 0xA5.
- spi_cs_o is low for 36 cycles.
- spi_clk_o shows 8 rising edges starting low.
REQ-034 SHALL cover: mode 3 driving an axis_spi_slave (mode 3) preloaded with 0x3C, master sends 0xC3.
- Master m_axis receives 0x3C.
- Slave m_axis receives 0xC3.
REQ-035 SHALL cover: modes 1 and 2, send 0x81 with loopback.
- m_axis receives 0x81.
- spi_clk_o idles at 0 for mode 1 and at 1 for mode 2.
REQ-036 SHALL cover backpressure: m_axis.tready held low, words 0x11 then 0x22 offered.
- 0x22 is not accepted until 0x11 is read.
- Received order is 0x11, 0x22.
REQ-037 SHALL cover reset mid-frame: arstn_i low after edge 5 of 0xFF.
- Next cycle: spi_cs_o=1, spi_clk_o=CPOL, m_axis.tvalid=0.
- A following 0x0F frame is received correctly.
REQ-038 SHALL cover back-to-back words: s_axis.tvalid held high with 0x01, 0x02, 0x03.
- spi_cs_o is high for at least CLK_DIV cycles between frames.
- Three m_axis words arrive in order.
